fp_multiplier_seq: RTL and testbench
====================================

# fp_multiplier_seq

Sequential IEEE-754 single-precision multiplier forming the product stage of the floating-point MAC datapath. It sits directly upstream of the combinational floating-point adder and its `result` feeds one adder operand. The mantissa product uses a radix-2 shift-add loop, one bit per cycle, under a start/busy/done handshake. Subnormal inputs and outputs are flushed to zero.

## Interface
- Parameters: none (format fixed to binary32).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  32  operand; captured on the accepted `start` edge.
- `B`  in  32  operand; captured on the accepted `start` edge.
- `result`  out  32  product; holds its value until the next completion.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid while it is high.

## Operation
- States:
  - IDLE: on `start`=1, latch A/B, clear accumulator, load bit counter = 23, go to MUL.
  - MUL: 24 cycles; if multiplier LSB = 1, add multiplicand to the 48-bit accumulator; shift; counter decrements; at 0 go to NORM.
  - NORM: normalise, round, handle special cases, write `result`, go to DONE.
  - DONE: `done`=1; next edge go to IDLE.
- Decode:
  - Sign = signA ^ signB.
  - Mantissa = {1, frac} if exp != 0, else the operand is zero (flush to zero).
- Exponent: 10-bit signed, eA + eB − 127.
  - If product bit 47 = 1: take bits [46:24] as the fraction, exponent +1.
  - Otherwise: take bits [45:23] as the fraction.
- Specials, evaluated in NORM. Latency is always the same.
  - Any NaN, or Inf × 0: output 0x7FC00000.
  - Inf × finite nonzero, or Inf × Inf: output sign|0x7F800000.
  - Either operand zero or subnormal: output sign|0x00000000.
- Range:
  - Final exponent ≥ 255: output sign|0x7F800000 (overflow).
  - Final exponent ≤ 0: output sign|0 (underflow, flush).
- A `start` while `busy` is ignored. The operand registers are not disturbed.

## Timing
- Reset values: state = IDLE, `result` = 0x00000000, `busy` = 0, `done` = 0, internal registers cleared.
- `start` accepted at edge k:
  - `busy` = 1 after edge k.
  - MUL covers edges k+1 … k+24.
  - NORM writes `result` at edge k+25; `done` = 1 during the cycle after edge k+25.
  - `done` = 0 and `busy` = 0 after edge k+26.
- Back-to-back: the earliest next acceptance is edge k+27, because `start` is sampled while in IDLE.
- `start` held high continuously re-triggers at each IDLE visit.
- `rst` asserted mid-operation aborts immediately. All outputs return to reset values, and a pending product is never reported.
- `result` changes only at the NORM edge or on reset.

## Configuration
- `FPMUL_ROUND_NEAREST_EN` defined:
  - Round-to-nearest-even using guard bit plus a sticky OR of the remaining product bits.
  - A rounding carry out of the mantissa increments the exponent; the overflow check is then re-applied.
- Undefined: truncation (round toward zero). Remaining bits are discarded.
- Latency is identical in both builds.

## Test plan
- Basic product: A = 0x40000000, B = 0x40400000, start pulse → `done` 26 cycles later, `result` = 0x40C00000, `busy` high for exactly 26 cycles.
- Signs: A = 0xBFC00000, B = 0x40000000 → 0xC0400000.
- Specials and range:
  - 0x7F000000 × 0x7F000000 → 0x7F800000.
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0x00400000 (subnormal) × 0x40000000 → 0x00000000.
- Rounding: A = B = 0x3FC00001 → 0x40100001 without the macro, 0x40100002 with `FPMUL_ROUND_NEAREST_EN`.
- Handshake: second `start` with new operands 5 cycles after the first → ignored, first product reported. A `start` in IDLE after `done` → accepted, new product 26 cycles later.
- Reset: assert `rst` 10 cycles into MUL → `busy` = `done` = 0 and `result` = 0 immediately. No `done` pulse follows; a fresh start completes normally.

Source files
------------

// File: rtl/fp_multiplier_seq.sv
// Sequential binary32 multiplier: radix-2 shift-add mantissa loop, flush-to-zero subnormals.
// Define FPMUL_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fp_multiplier_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplr_q, mplr_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic [23:0] mant_a_in, mant_b_in;
    assign mant_a_in = (A[30:23] != 8'd0) ? {1'b1, A[22:0]} : 24'd0;
    assign mant_b_in = (B[30:23] != 8'd0) ? {1'b1, B[22:0]} : 24'd0;

    // Operand classification from the latched operands
    logic       sign_p;
    logic       nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    assign sign_p = a_q[31] ^ b_q[31];
    assign nan_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    assign nan_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    assign inf_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    assign inf_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    assign zero_a = (a_q[30:23] == 8'd0);
    assign zero_b = (b_q[30:23] == 8'd0);

    logic signed [9:0] exp_raw, exp_n, exp_f;
    logic [22:0]       frac_t, frac_f;
    logic [31:0]       norm_result;

`ifdef FPMUL_ROUND_NEAREST_EN
    logic        guard, sticky, round_up, carry;
    always_comb begin
        guard  = acc_q[47] ? acc_q[23] : acc_q[22];
        sticky = acc_q[47] ? (|acc_q[22:0]) : (|acc_q[21:0]);
        round_up = guard & (sticky | frac_t[0]);
        {carry, frac_f} = {1'b0, frac_t} + {23'd0, round_up};
        exp_f = exp_n + $signed({9'd0, carry});
    end
`else
    logic unused_lo;
    assign unused_lo = ^acc_q[22:0];
    assign frac_f    = frac_t;
    assign exp_f     = exp_n;
`endif

    always_comb begin
        exp_raw = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
        exp_n   = exp_raw + $signed({9'd0, acc_q[47]});
        frac_t  = acc_q[47] ? acc_q[46:24] : acc_q[45:23];

        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            norm_result = 32'h7FC0_0000;
        end else if (inf_a || inf_b) begin
            norm_result = {sign_p, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            norm_result = {sign_p, 31'd0};
        end else if (exp_f >= 10'sd255) begin
            norm_result = {sign_p, 8'hFF, 23'd0};
        end else if (exp_f <= 10'sd0) begin
            norm_result = {sign_p, 31'd0};
        end else begin
            norm_result = {sign_p, exp_f[7:0], frac_f};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    mcand_d = {24'd0, mant_a_in};
                    mplr_d  = mant_b_in;
                    acc_d   = 48'd0;
                    cnt_d   = 5'd23;
                    state_d = StMul;
                end
            end
            StMul: begin
                acc_d   = acc_q + (mplr_q[0] ? mcand_q : 48'd0);
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                if (cnt_q == 5'd0) begin
                    state_d = StNorm;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StNorm: begin
                result_d = norm_result;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            mcand_q  <= 48'd0;
            mplr_q   <= 24'd0;
            acc_q    <= 48'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Self-checking bench for fp_multiplier_seq: directed spec cases plus random operands
// checked against an arithmetic reference model.
module tb_fp_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] prev_res = 32'd0;

    fp_multiplier_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: integer mantissa product, normalise, optional RNE by remainder vs half-ulp.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e;
        longint unsigned fa, fb, p, frac, rem, half;
        bit nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        nan_a = (ea == 255) && (fa != 0);
        nan_b = (eb == 255) && (fb != 0);
        inf_a = (ea == 255) && (fa == 0);
        inf_b = (eb == 255) && (fb == 0);
        z_a = (ea == 0);
        z_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) return 32'h7FC00000;
        if (inf_a || inf_b) return {s, 31'h7F800000};
        if (z_a || z_b) return {s, 31'd0};
        p = (fa + 64'd8388608) * (fb + 64'd8388608);
        e = ea + eb - 127;
        if (p >= 64'h8000_0000_0000) begin
            frac = (p / 64'd16777216) % 64'd8388608;
            rem  = p % 64'd16777216;
            half = 64'd8388608;
            e    = e + 1;
        end else begin
            frac = (p / 64'd8388608) % 64'd8388608;
            rem  = p % 64'd8388608;
            half = 64'd4194304;
        end
`ifdef FPMUL_ROUND_NEAREST_EN
        if (rem > half || (rem == half && frac % 2 == 1)) begin
            frac = frac + 1;
            if (frac == 64'd8388608) begin
                frac = 0;
                e    = e + 1;
            end
        end
`else
        if (rem > half) frac = frac;
`endif
        if (e >= 255) return {s, 31'h7F800000};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(frac)};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] pool [7] = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                  32'h7FC00000, 32'h00400000, 32'h3F800000};
        int k;
        logic s;
        logic [7:0] e;
        logic [22:0] f;
        k = int'($urandom_range(0, 9));
        s = 1'($urandom_range(0, 1));
        e = 8'($urandom_range(60, 195));
        f = 23'($urandom());
        if (k == 0) return pool[$urandom_range(0, 6)];
        if (k == 1) return $urandom();
        return {s, e, f};
    endfunction

    // One operation from idle; optional intruding start with other operands at cycle poke_at.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int poke_at,
                          input logic [31:0] a2, input logic [31:0] b2);
        int n = 0;
        int busy_n = 0;
        bit seen = 0;
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        @(negedge clk);
        start = 1'b0;
        while (!seen && n < 40) begin
            n++;
            if (busy) busy_n++;
            if (n == poke_at) begin
                chk({tag, "_hold"}, result, prev_res);
                start = 1'b1;
                A = a2;
                B = b2;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1;
            else @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'd26);
        chk({tag, "_busycyc"}, 32'(busy_n), 32'd26);
        chk({tag, "_result"}, result, expv);
        prev_res = expv;
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int t, first, second;
        bit spur;
        logic [31:0] ra, rb;

        repeat (2) @(negedge clk);
        chk("reset_out", {result[31:2], 2'b00} | {30'd0, busy, done}, 32'd0);
        rst = 1'b0;

        do_mul("basic", 32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);
        do_mul("sign", 32'hBFC00000, 32'h40000000, 32'hC0400000, 0, 0, 0);
        do_mul("ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 0, 0, 0);
        do_mul("infzero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 0);
        do_mul("subn", 32'h00400000, 32'h40000000, 32'h00000000, 0, 0, 0);
`ifdef FPMUL_ROUND_NEAREST_EN
        do_mul("round", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 0, 0, 0);
`else
        do_mul("round", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 0, 0, 0);
`endif
        do_mul("ninf", 32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 0);
        do_mul("undf", 32'h00800000, 32'h3F000000, 32'h00000000, 0, 0, 0);

        // Start while busy must be ignored
        do_mul("ignore", 32'h40400000, 32'h40400000, 32'h41100000, 5, 32'h3F800000,
               32'h3F800000);
        do_mul("after", 32'h40800000, 32'h3F000000, 32'h40000000, 0, 0, 0);

        // Start held high: re-trigger every 27 cycles
        @(negedge clk);
        start = 1'b1;
        A = 32'h40A00000;
        B = 32'h40000000;
        t = 0;
        first = -1;
        second = -1;
        while (second < 0 && t < 80) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (first < 0) first = t;
                else second = t;
            end
        end
        start = 1'b0;
        chk("held_first", 32'(first), 32'd26);
        chk("held_gap", 32'(second - first), 32'd27);
        chk("held_result", result, 32'h41200000);
        prev_res = 32'h41200000;
        @(negedge clk);
        chk("held_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of MUL
        @(negedge clk);
        start = 1'b1;
        A = 32'h40000000;
        B = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_res = 32'd0;
        spur = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) spur = 1;
        end
        chk("rst_nodone", {31'd0, spur}, 32'd0);
        do_mul("fresh", 32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = rand_op();
            rb = rand_op();
            do_mul($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb), 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
